// File: rtl/fetch_decode_queue_if.sv
// Signal bundle between the IF/ID queue, the instruction fetcher and the decoder.
// The master side is the queue; the slave side is the fetcher/decoder/execute environment.
interface fetch_decode_queue_if #(
    parameter int XLEN = 64
);
    logic            fetch_enable;
    logic [XLEN-1:0] pc_current;
    logic            fetcher_done;
    logic [63:0]     instruction_in;
    logic            if_id_valid;

    logic            flush;
    logic [XLEN-1:0] flush_target;

    logic            dec_valid;
    logic            dec_ready;
    logic [31:0]     dec_instruction;
    logic [XLEN-1:0] dec_pc;

    modport master (
        output fetch_enable, pc_current, if_id_valid,
        output dec_valid, dec_instruction, dec_pc,
        input  fetcher_done, instruction_in,
        input  flush, flush_target,
        input  dec_ready
    );

    modport slave (
        input  fetch_enable, pc_current, if_id_valid,
        input  dec_valid, dec_instruction, dec_pc,
        output fetcher_done, instruction_in,
        output flush, flush_target,
        output dec_ready
    );
endinterface

// File: rtl/fetch_decode_queue.sv
// IF/ID boundary: owns the fetch PC, runs the fetcher's 4-phase done/ack handshake and
// buffers {pc, instruction} pairs in a small FIFO for the decoder.
//
//   state | meaning
//   IDLE  | no fetch outstanding; start one when a queue slot is free and no flush
//   BUSY  | fetch_enable high, pc_current=req_pc, waiting for fetcher_done
//   ACK   | data captured; if_id_valid high until fetcher_done drops
module fetch_decode_queue #(
    parameter int              DEPTH    = 2,
    parameter int              XLEN     = 64,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                 clk,
    input  logic                 reset,
    fetch_decode_queue_if.master bus
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        ACK  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] req_pc_q, req_pc_d;
    logic [XLEN-1:0] pc_reg_q, pc_reg_d;
    logic            stale_q, stale_d;
    logic            fetch_en_q, fetch_en_d;
    logic            if_id_valid_q, if_id_valid_d;

    logic [CW-1:0]   count_q, count_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [31:0]     insn_mem_q [DEPTH];
    logic [XLEN-1:0] pc_mem_q   [DEPTH];

    logic            push;
    logic            pop;
    logic            dec_valid;
    logic [31:0]     insn_sel;

    assign insn_sel  = req_pc_q[2] ? bus.instruction_in[63:32] : bus.instruction_in[31:0];
    assign dec_valid = (count_q != '0);
    assign pop       = dec_valid && bus.dec_ready && !bus.flush;

    // Fetch control. A flush while data is still owed marks that fetch stale so its
    // data is dropped on arrival, but the fetcher transaction itself is never cut short.
    always_comb begin
        state_d  = state_q;
        req_pc_d = req_pc_q;
        pc_reg_d = pc_reg_q;
        stale_d  = stale_q;
        push     = 1'b0;

        case (state_q)
            IDLE: begin
                if ((count_q < DEPTH_C) && !bus.flush) begin
                    req_pc_d = pc_reg_q;
                    state_d  = BUSY;
                end
            end
            BUSY: begin
                if (bus.fetcher_done) begin
                    state_d = ACK;
                    stale_d = 1'b0;
                    if (!stale_q && !bus.flush) begin
                        push     = 1'b1;
                        pc_reg_d = req_pc_q + XLEN'(4);
                    end
                end else if (bus.flush) begin
                    stale_d = 1'b1;
                end
            end
            ACK: begin
                if (!bus.fetcher_done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (bus.flush) begin
            pc_reg_d = bus.flush_target;
        end

        fetch_en_d    = (state_d != IDLE);
        if_id_valid_d = (state_d == ACK);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            req_pc_q      <= '0;
            pc_reg_q      <= RESET_PC;
            stale_q       <= 1'b0;
            fetch_en_q    <= 1'b0;
            if_id_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            req_pc_q      <= req_pc_d;
            pc_reg_q      <= pc_reg_d;
            stale_q       <= stale_d;
            fetch_en_q    <= fetch_en_d;
            if_id_valid_q <= if_id_valid_d;
        end
    end

    // Queue bookkeeping; a flush wins over any same-cycle push or pop.
    always_comb begin
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;

        if (bus.flush) begin
            count_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            insn_mem_q[wr_ptr_q] <= insn_sel;
            pc_mem_q[wr_ptr_q]   <= req_pc_q;
        end
    end

    assign bus.fetch_enable    = fetch_en_q;
    assign bus.if_id_valid     = if_id_valid_q;
    assign bus.pc_current      = req_pc_q;
    assign bus.dec_valid       = dec_valid;
    assign bus.dec_instruction = insn_mem_q[rd_ptr_q];
    assign bus.dec_pc          = pc_mem_q[rd_ptr_q];

endmodule

// File: tb/tb_fetch_decode_queue.sv
// Bench for fetch_decode_queue: behavioural fetcher, expected-PC scoreboard, one task per scenario.
module tb_fetch_decode_queue;

    logic clk;
    logic reset;

    fetch_decode_queue_if #(.XLEN(64)) bus();

    fetch_decode_queue #(
        .DEPTH    (2),
        .XLEN     (64),
        .RESET_PC (64'h0)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] insn;
    } exp_t;

    exp_t        exp_q[$];
    logic [63:0] acked[$];
    int          total;
    int          bad;
    int          extra_hold;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Cache line for a PC: low word = aligned base, high word = (base+4) tagged.
    function automatic logic [63:0] line_for(input logic [63:0] pc);
        logic [31:0] b;
        b = pc[31:0] & ~32'h7;
        return {(b + 32'd4) ^ 32'hC0DE_0000, b};
    endfunction

    function automatic logic [31:0] exp_insn(input logic [63:0] pc);
        return pc[2] ? (pc[31:0] ^ 32'hC0DE_0000) : pc[31:0];
    endfunction

    function automatic void expect_pc(input logic [63:0] pc);
        exp_q.push_back({pc, exp_insn(pc)});
    endfunction

    // Fetcher: done two cycles after enable, held until if_id_valid plus extra_hold cycles.
    initial begin
        int          f_cnt;
        int          f_hold;
        bit          f_seen;
        logic [63:0] f_pc;
        f_cnt = 0; f_hold = 0; f_seen = 0; f_pc = '0;
        bus.fetcher_done   = 1'b0;
        bus.instruction_in = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                bus.fetcher_done = 1'b0;
                f_cnt = 0; f_hold = 0; f_seen = 0;
                acked.delete();
            end else if (!bus.fetcher_done) begin
                if (bus.fetch_enable && !bus.if_id_valid) begin
                    f_cnt++;
                    if (f_cnt == 2) begin
                        f_pc               = bus.pc_current;
                        bus.instruction_in = line_for(bus.pc_current);
                        bus.fetcher_done   = 1'b1;
                        f_cnt = 0; f_hold = extra_hold; f_seen = 0;
                    end
                end else begin
                    f_cnt = 0;
                end
            end else if (bus.if_id_valid) begin
                if (!f_seen) begin
                    acked.push_back(f_pc);
                    f_seen = 1;
                end
                if (f_hold == 0) bus.fetcher_done = 1'b0;
                else f_hold--;
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        bus.flush = 1'b0;
        bus.flush_target = '0;
        bus.dec_ready = 1'b0;
        extra_hold = 0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        total++; if (bus.fetch_enable !== 1'b0) begin bad++; $display("FAIL reset_fetch_enable: got %b want 0", bus.fetch_enable); end
        total++; if (bus.if_id_valid !== 1'b0) begin bad++; $display("FAIL reset_if_id_valid: got %b want 0", bus.if_id_valid); end
        total++; if (bus.dec_valid !== 1'b0) begin bad++; $display("FAIL reset_dec_valid: got %b want 0", bus.dec_valid); end
        total++; if (bus.pc_current !== 64'h0) begin bad++; $display("FAIL reset_pc_current: got %h want 0", bus.pc_current); end
    endtask

    task automatic test_fetch_order();
        exp_t e;
        int   budget;
        do_reset();
        bus.dec_ready = 1'b1;
        expect_pc(64'h0); expect_pc(64'h4); expect_pc(64'h8); expect_pc(64'hC);
        budget = 100;
        while (exp_q.size() != 0 && budget > 0) begin
            @(negedge clk); budget--;
            if (bus.dec_valid && bus.dec_ready && !bus.flush) begin
                e = exp_q.pop_front();
                total++;
                if (bus.dec_pc !== e.pc || bus.dec_instruction !== e.insn) begin
                    bad++;
                    $display("FAIL order_pop: got pc=%h insn=%h want pc=%h insn=%h", bus.dec_pc, bus.dec_instruction, e.pc, e.insn);
                end
            end
        end
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL order_timeout: %0d left want 0", exp_q.size()); end
    endtask

    task automatic test_backpressure();
        exp_t e;
        int   budget;
        bit   fe_seen;
        do_reset();
        repeat (30) @(negedge clk);
        fe_seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.fetch_enable) fe_seen = 1;
        end
        total++; if (fe_seen !== 1'b0) begin bad++; $display("FAIL bp_fetch_enable: got 1 want 0"); end
        total++; if (acked.size() != 2) begin bad++; $display("FAIL bp_fetch_count: got %0d want 2", acked.size()); end
        total++; if (bus.dec_valid !== 1'b1 || bus.dec_pc !== 64'h0) begin
            bad++; $display("FAIL bp_head: got valid=%b pc=%h want valid=1 pc=0", bus.dec_valid, bus.dec_pc);
        end
        expect_pc(64'h0); expect_pc(64'h4); expect_pc(64'h8);
        budget = 100;
        while (exp_q.size() != 0 && budget > 0) begin
            @(negedge clk); budget--;
            bus.dec_ready = 1'b1;
            if (bus.dec_valid && bus.dec_ready && !bus.flush) begin
                e = exp_q.pop_front();
                total++;
                if (bus.dec_pc !== e.pc || bus.dec_instruction !== e.insn) begin
                    bad++;
                    $display("FAIL bp_pop: got pc=%h insn=%h want pc=%h insn=%h", bus.dec_pc, bus.dec_instruction, e.pc, e.insn);
                end
            end
        end
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL bp_timeout: %0d left want 0", exp_q.size()); end
    endtask

    task automatic test_flush_busy();
        exp_t e;
        int   budget;
        bit   flushed;
        do_reset();
        bus.dec_ready = 1'b1;
        expect_pc(64'h0); expect_pc(64'h4);
        flushed = 0;
        budget = 150;
        while ((exp_q.size() != 0 || !flushed) && budget > 0) begin
            @(negedge clk); budget--;
            if (bus.flush) bus.flush = 1'b0;
            if (!flushed && bus.fetch_enable && !bus.if_id_valid && bus.pc_current == 64'h8) begin
                bus.flush = 1'b1;
                bus.flush_target = 64'h100;
                flushed = 1;
                expect_pc(64'h100); expect_pc(64'h104);
            end
            if (bus.dec_valid && bus.dec_ready && !bus.flush) begin
                e = exp_q.pop_front();
                total++;
                if (bus.dec_pc !== e.pc || bus.dec_instruction !== e.insn) begin
                    bad++;
                    $display("FAIL flush_busy_pop: got pc=%h insn=%h want pc=%h insn=%h", bus.dec_pc, bus.dec_instruction, e.pc, e.insn);
                end
            end
        end
        total++; if (exp_q.size() != 0 || !flushed) begin bad++; $display("FAIL flush_busy_timeout: %0d left flushed=%0d want 0 left flushed=1", exp_q.size(), flushed); end
        total++;
        if (acked.size() < 4) begin
            bad++; $display("FAIL flush_busy_acks: got %0d handshakes want at least 4", acked.size());
        end else if (acked[2] !== 64'h8 || acked[3] !== 64'h100) begin
            bad++; $display("FAIL flush_busy_acks: got %h,%h want 8,100", acked[2], acked[3]);
        end
    endtask

    task automatic test_flush_with_pop();
        exp_t e;
        int   budget;
        do_reset();
        repeat (30) @(negedge clk);
        total++; if (bus.dec_valid !== 1'b1) begin bad++; $display("FAIL fpop_pre_valid: got %b want 1", bus.dec_valid); end
        @(negedge clk);
        bus.flush = 1'b1;
        bus.flush_target = 64'h200;
        bus.dec_ready = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        total++; if (bus.dec_valid !== 1'b0) begin bad++; $display("FAIL fpop_valid_after: got %b want 0", bus.dec_valid); end
        total++; if (bus.fetch_enable !== 1'b0) begin bad++; $display("FAIL fpop_blocked: got %b want 0", bus.fetch_enable); end
        expect_pc(64'h200); expect_pc(64'h204);
        budget = 100;
        while (exp_q.size() != 0 && budget > 0) begin
            if (budget != 100) @(negedge clk);
            budget--;
            if (bus.dec_valid && bus.dec_ready && !bus.flush) begin
                e = exp_q.pop_front();
                total++;
                if (bus.dec_pc !== e.pc || bus.dec_instruction !== e.insn) begin
                    bad++;
                    $display("FAIL fpop_pop: got pc=%h insn=%h want pc=%h insn=%h", bus.dec_pc, bus.dec_instruction, e.pc, e.insn);
                end
            end
        end
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL fpop_timeout: %0d left want 0", exp_q.size()); end
    endtask

    task automatic test_long_done();
        exp_t e;
        int   budget;
        int   high;
        do_reset();
        extra_hold = 3;
        budget = 40;
        while (!bus.if_id_valid && budget > 0) begin @(negedge clk); budget--; end
        high = 0;
        while (bus.if_id_valid && high < 20) begin high++; @(negedge clk); end
        total++; if (high != 1 + extra_hold) begin bad++; $display("FAIL long_done_ack_len: got %0d want %0d", high, 1 + extra_hold); end
        total++; if (bus.dec_valid !== 1'b1 || bus.dec_pc !== 64'h0) begin
            bad++; $display("FAIL long_done_head: got valid=%b pc=%h want valid=1 pc=0", bus.dec_valid, bus.dec_pc);
        end
        bus.dec_ready = 1'b1;
        expect_pc(64'h0); expect_pc(64'h4);
        budget = 150;
        while (exp_q.size() != 0 && budget > 0) begin
            if (budget != 150) @(negedge clk);
            budget--;
            if (bus.dec_valid && bus.dec_ready && !bus.flush) begin
                e = exp_q.pop_front();
                total++;
                if (bus.dec_pc !== e.pc || bus.dec_instruction !== e.insn) begin
                    bad++;
                    $display("FAIL long_done_pop: got pc=%h insn=%h want pc=%h insn=%h", bus.dec_pc, bus.dec_instruction, e.pc, e.insn);
                end
            end
        end
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL long_done_timeout: %0d left want 0", exp_q.size()); end
    endtask

    task automatic test_reset_in_ack();
        exp_t e;
        int   budget;
        do_reset();
        extra_hold = 3;
        budget = 40;
        while (!bus.if_id_valid && budget > 0) begin @(negedge clk); budget--; end
        total++; if (bus.if_id_valid !== 1'b1 || bus.dec_valid !== 1'b1) begin
            bad++; $display("FAIL rst_ack_pre: got ack=%b valid=%b want 1,1", bus.if_id_valid, bus.dec_valid);
        end
        reset = 1'b1;
        @(negedge clk);
        total++; if ({bus.fetch_enable, bus.if_id_valid, bus.dec_valid} !== 3'b000 || bus.pc_current !== 64'h0) begin
            bad++; $display("FAIL rst_ack_outputs: got fe=%b ack=%b valid=%b pc=%h want 0,0,0,0",
                            bus.fetch_enable, bus.if_id_valid, bus.dec_valid, bus.pc_current);
        end
        @(negedge clk);
        reset = 1'b0;
        extra_hold = 0;
        bus.dec_ready = 1'b1;
        exp_q.delete();
        expect_pc(64'h0); expect_pc(64'h4);
        budget = 100;
        while (exp_q.size() != 0 && budget > 0) begin
            @(negedge clk); budget--;
            if (bus.dec_valid && bus.dec_ready && !bus.flush) begin
                e = exp_q.pop_front();
                total++;
                if (bus.dec_pc !== e.pc || bus.dec_instruction !== e.insn) begin
                    bad++;
                    $display("FAIL rst_ack_pop: got pc=%h insn=%h want pc=%h insn=%h", bus.dec_pc, bus.dec_instruction, e.pc, e.insn);
                end
            end
        end
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL rst_ack_timeout: %0d left want 0", exp_q.size()); end
    endtask

    initial begin
        total = 0;
        bad = 0;
        extra_hold = 0;
        reset = 1'b1;
        bus.flush = 1'b0;
        bus.flush_target = '0;
        bus.dec_ready = 1'b0;
        test_reset();
        test_fetch_order();
        test_backpressure();
        test_flush_busy();
        test_flush_with_pop();
        test_long_done();
        test_reset_in_ack();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
